// File: rtl/riscv_fetch_pkg.sv
// Shared types and helpers for the instruction-side prefetch path.
package riscv_fetch_pkg;

   typedef enum logic {
      STREAM   = 1'b0,
      REDIRECT = 1'b1
   } fetch_state_e;

   localparam int unsigned WORD_BYTES = 4;
   localparam int unsigned MAX_ADDR_W = 64;

   function automatic logic [MAX_ADDR_W-1:0] word_align(input logic [MAX_ADDR_W-1:0] addr);
      return addr & ~MAX_ADDR_W'(WORD_BYTES - 1);
   endfunction

endpackage

// File: rtl/instr_prefetch_if.sv
// Avalon-MM read bus: host drives the command, agent returns data and stalls.
interface instr_prefetch_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
);

   logic [ADDR_W-1:0] address;
   logic              read;
   logic [DATA_W-1:0] readdata;
   logic              waitrequest;
   logic              readdatavalid;

   modport master (
      output address, read,
      input  readdata, waitrequest, readdatavalid
   );

   modport slave (
      input  address, read,
      output readdata, waitrequest, readdatavalid
   );

endinterface

// File: rtl/prefetch_fifo.sv
// Synchronous first-word-fall-through FIFO; a pop and push on a full FIFO in one cycle is legal.
module prefetch_fifo #(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned DATA_W = 32
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clr_i,
   input  logic                     push_i,
   input  logic [DATA_W-1:0]        data_i,
   input  logic                     pop_i,
   output logic [DATA_W-1:0]        data_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [PW-1:0]     rd_ptr_q, wr_ptr_q;
   logic [CW-1:0]     count_q;
   logic              do_push, do_pop;

   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign data_o  = mem_q[rd_ptr_q];

   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else if (clr_i) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
         count_q <= count_q + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !clr_i) mem_q[wr_ptr_q] <= data_i;
   end

endmodule

// File: rtl/instr_prefetch.sv
// Instruction prefetch buffer: streams sequential Rom words ahead of the CPU and
// flushes through a one-cycle REDIRECT on any non-sequential fetch.
module instr_prefetch
   import riscv_fetch_pkg::*;
#(
   parameter int unsigned       DEPTH    = 4,
   parameter int unsigned       ADDR_W   = 32,
   parameter int unsigned       DATA_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   instr_prefetch_if.slave   cpu,
   instr_prefetch_if.master  rom
);

   localparam int unsigned CW = $clog2(DEPTH) + 1;

   fetch_state_e      state_q, state_d;
   logic [ADDR_W-1:0] fetch_ptr_q, fetch_ptr_d;
   logic [ADDR_W-1:0] head_addr_q, head_addr_d;
   logic [CW-1:0]     outst_q, outst_d;
   logic [CW-1:0]     drop_q, drop_d;
   logic              en_q;

   logic [ADDR_W-1:0] cpu_word_addr;
   logic [DATA_W-1:0] fifo_head;
   logic [CW-1:0]     fifo_count;
   logic              fifo_full, fifo_empty;
   logic              issue, accept, rsp, addr_match, hit, miss, push, clr;

   assign cpu_word_addr = ADDR_W'(word_align(MAX_ADDR_W'(cpu.address)));

   prefetch_fifo #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst),
      .clr_i   (clr),
      .push_i  (push),
      .data_i  (rom.readdata),
      .pop_i   (hit),
      .data_o  (fifo_head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   always_comb begin
      // In-flight reads still to be dropped stay in outst_q, so buffered plus
      // in-flight words never exceed DEPTH.
      issue      = en_q && (state_q == STREAM) && ((fifo_count + outst_q) < CW'(DEPTH));
      accept     = issue && !rom.waitrequest;
      rsp        = rom.readdatavalid;
      addr_match = (cpu_word_addr == head_addr_q);
      hit        = (state_q == STREAM) && cpu.read && !fifo_empty && addr_match;
      miss       = (state_q == STREAM) && cpu.read && !addr_match;
      push       = (state_q == STREAM) && rsp && (drop_q == '0);
      clr        = (state_q == REDIRECT);

      state_d     = state_q;
      fetch_ptr_d = fetch_ptr_q;
      head_addr_d = head_addr_q;
      outst_d     = outst_q;
      drop_d      = drop_q;

      unique case (state_q)
         STREAM: begin
            if (accept) fetch_ptr_d = fetch_ptr_q + ADDR_W'(WORD_BYTES);
            if (hit)    head_addr_d = head_addr_q + ADDR_W'(WORD_BYTES);
            outst_d = outst_q + CW'(accept) - CW'(rsp);
            if (rsp && (drop_q != '0)) drop_d = drop_q - CW'(1);
            if (miss) state_d = REDIRECT;
         end
         REDIRECT: begin
            fetch_ptr_d = cpu_word_addr;
            head_addr_d = cpu_word_addr;
            outst_d     = outst_q - CW'(rsp);
            // drop_q never exceeds outst_q, so every read still in flight is stale.
            drop_d      = outst_q - CW'(rsp);
            state_d     = STREAM;
         end
         default: state_d = STREAM;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= STREAM;
         fetch_ptr_q <= RESET_PC;
         head_addr_q <= RESET_PC;
         outst_q     <= '0;
         drop_q      <= '0;
         en_q        <= 1'b0;
      end else begin
         state_q     <= state_d;
         fetch_ptr_q <= fetch_ptr_d;
         head_addr_q <= head_addr_d;
         outst_q     <= outst_d;
         drop_q      <= drop_d;
         en_q        <= 1'b1;
      end
   end

   assign rom.read          = issue;
   assign rom.address       = fetch_ptr_q;
   assign cpu.waitrequest   = !hit;
   assign cpu.readdata      = hit ? fifo_head : '0;
   assign cpu.readdatavalid = hit;

   a_no_overflow : assert property (@(posedge clk) disable iff (!rst)
      !(push && fifo_full && !hit));

endmodule

// File: tb/tb_instr_prefetch.sv
// Bench for instr_prefetch: Rom model with configurable latency, CPU fetch scoreboard.
module tb_instr_prefetch;

   localparam int unsigned DEPTH  = 4;
   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;

   logic clk;
   logic rst;

   instr_prefetch_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) cpu_bus ();
   instr_prefetch_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) rom_bus ();

   instr_prefetch #(
      .DEPTH    (DEPTH),
      .ADDR_W   (ADDR_W),
      .DATA_W   (DATA_W),
      .RESET_PC (32'h0)
   ) dut (
      .clk (clk),
      .rst (rst),
      .cpu (cpu_bus),
      .rom (rom_bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      bit          zero_wait;
   } vec_t;

   typedef struct {
      logic [31:0] addr;
      int unsigned due;
   } rsp_t;

   vec_t        tbl [24];
   rsp_t        pipe_q [$];
   logic [31:0] acc_q [$];
   logic [31:0] exp_q [$];
   int unsigned rom_lat;
   int unsigned cyc;
   int          checks = 0;
   int          errors = 0;

   function automatic logic [31:0] rom_word(input logic [31:0] a);
      return a ^ 32'hA5A5_5A5A;
   endfunction

   function automatic logic [31:0] acc_at(input int i);
      if (i >= 0 && i < acc_q.size()) return acc_q[i];
      return 32'hDEAD_DEAD;
   endfunction

   function automatic int find_acc(input logic [31:0] a);
      for (int i = 0; i < acc_q.size(); i++)
         if (acc_q[i] == a) return i;
      return -1;
   endfunction

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h", name, got, exp);
      end
   endtask

   // Rom: accepts at most one command per cycle, answers in order after rom_lat cycles.
   initial begin : rom_model
      rsp_t r;
      cyc = 0;
      rom_bus.readdatavalid = 1'b0;
      rom_bus.readdata      = '0;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         if (!rst) begin
            pipe_q.delete();
            rom_bus.readdatavalid = 1'b0;
         end else if (pipe_q.size() > 0 && pipe_q[0].due <= cyc) begin
            r = pipe_q.pop_front();
            rom_bus.readdatavalid = 1'b1;
            rom_bus.readdata      = rom_word(r.addr);
         end else begin
            rom_bus.readdatavalid = 1'b0;
         end
         @(negedge clk);
         if (rst && rom_bus.read && !rom_bus.waitrequest) begin
            r.addr = rom_bus.address;
            r.due  = cyc + rom_lat;
            pipe_q.push_back(r);
            acc_q.push_back(rom_bus.address);
         end
      end
   end

   task automatic cpu_fetch(input logic [31:0] a, output int waits);
      logic [31:0] exp;
      bit done;
      done = 1'b0;
      cpu_bus.address = a;
      cpu_bus.read    = 1'b1;
      exp_q.push_back(rom_word(a));
      waits = 0;
      while (!done) begin
         @(negedge clk);
         if (!cpu_bus.waitrequest) begin
            exp = exp_q.pop_front();
            check($sformatf("rdata@%0h", a), cpu_bus.readdata, exp);
            done = 1'b1;
         end else if (waits >= 40) begin
            exp = exp_q.pop_front();
            checks++;
            errors++;
            $display("FAIL fetch_timeout addr=0x%0h waited=%0d required<=40", a, waits);
            done = 1'b1;
         end else begin
            waits++;
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic run_table(input int lo, input int hi);
      int w;
      for (int i = lo; i <= hi; i++) begin
         cpu_fetch(tbl[i].addr, w);
         if (tbl[i].zero_wait) check($sformatf("zero_wait[%0d]", i), 64'(w), 64'd0);
      end
      cpu_bus.read = 1'b0;
   endtask

   task automatic do_reset();
      rst                 = 1'b0;
      cpu_bus.read        = 1'b0;
      cpu_bus.address     = '0;
      rom_bus.waitrequest = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      acc_q.delete();
      exp_q.delete();
      rst = 1'b1;
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int  w;
      int  k;
      bit  ok;

      for (int i = 0; i < 8; i++) tbl[i] = '{32'(4 * i), (i != 0)};
      for (int i = 0; i < 4; i++) tbl[8 + i] = '{32'(4 * i), 1'b1};
      for (int i = 0; i < 4; i++) tbl[12 + i] = '{32'(4 * i), (i < 2)};
      tbl[16] = '{32'h100, 1'b0};
      tbl[17] = '{32'h104, 1'b0};
      tbl[18] = '{32'h108, 1'b0};
      tbl[19] = '{32'hFFFF_FFFC, 1'b0};
      tbl[20] = '{32'h0, 1'b1};
      tbl[21] = '{32'h4, 1'b1};
      tbl[22] = '{32'h0, 1'b0};
      tbl[23] = '{32'h4, 1'b1};

      // Reset state, then sequential run with latency 1
      rom_lat             = 1;
      rst                 = 1'b0;
      cpu_bus.read        = 1'b0;
      cpu_bus.address     = '0;
      rom_bus.waitrequest = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_rom_read", rom_bus.read, 0);
      check("rst_rom_addr", rom_bus.address, 32'h0);
      check("rst_cpu_wait", cpu_bus.waitrequest, 1);
      check("rst_cpu_rdata", cpu_bus.readdata, 32'h0);
      rst = 1'b1;
      run_table(0, 7);
      for (int i = 0; i < 8; i++) check($sformatf("seq_rom_addr[%0d]", i), acc_at(i), 32'(4 * i));

      // CPU idle: prefetch stops at DEPTH words
      do_reset();
      repeat (10) @(posedge clk);
      @(negedge clk);
      check("idle_rom_read", rom_bus.read, 0);
      check("idle_accepts", 64'(acc_q.size()), 64'(DEPTH));
      @(posedge clk);
      #1;
      run_table(8, 11);

      // Branch to 0x100 with reads in flight, latency 3
      rom_lat = 3;
      do_reset();
      repeat (3) @(posedge clk);
      #1;
      cpu_fetch(32'h100, w);
      check("redirect_latency_ge5", (w >= 5), 1);
      run_table(17, 18);
      k  = find_acc(32'h100);
      ok = (k >= 0);
      for (int j = 0; j < k; j++) if (acc_q[j] != 32'(4 * j)) ok = 1'b0;
      check("redirect_prefix", ok, 1);
      check("redirect_next_addr", acc_at(k + 1), 32'h104);

      // Rom waitrequest held for 5 cycles at 0x8
      rom_lat = 1;
      do_reset();
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         if (rom_bus.read && rom_bus.address == 32'h8) begin
            rom_bus.waitrequest = 1'b1;
            ok = 1'b1;
         end else begin
            @(posedge clk);
            #1;
         end
      end
      check("wait_addr_seen", ok, 1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check($sformatf("hold_read[%0d]", i), rom_bus.read, 1);
         check($sformatf("hold_addr[%0d]", i), rom_bus.address, 32'h8);
         @(posedge clk);
         #1;
      end
      check("no_accept_in_wait", 64'(acc_q.size()), 64'd2);
      rom_bus.waitrequest = 1'b0;
      @(posedge clk);
      #1;
      check("ptr_after_accept", rom_bus.address, 32'hC);
      check("accepts_after_wait", 64'(acc_q.size()), 64'd3);
      run_table(12, 15);

      // Wrap-around from 0xFFFFFFFC
      do_reset();
      run_table(19, 21);
      k = find_acc(32'hFFFF_FFFC);
      check("wrap_seen", (k >= 0), 1);
      check("wrap_next_addr", acc_at(k + 1), 32'h0);

      // Async reset mid-operation
      rom_lat = 3;
      do_reset();
      repeat (6) @(posedge clk);
      #1;
      cpu_bus.address = 32'h0;
      cpu_bus.read    = 1'b1;
      #1;
      check("pre_rst_hit", cpu_bus.waitrequest, 0);
      check("pre_rst_rdata", cpu_bus.readdata, rom_word(32'h0));
      rst = 1'b0;
      #1;
      check("async_rom_read", rom_bus.read, 0);
      check("async_rom_addr", rom_bus.address, 32'h0);
      check("async_cpu_wait", cpu_bus.waitrequest, 1);
      check("async_cpu_rdata", cpu_bus.readdata, 32'h0);
      cpu_bus.read = 1'b0;
      do_reset();
      run_table(22, 23);
      check("restart_addr", acc_at(0), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
